tx_data_buffer: RTL
===================

// Module: tx_data_buffer
// PURPOSE
//   Byte FIFO directly upstream of the USB transmitter. The host side stores packet payload bytes.
//   The transmitter pulls bytes with get_tx_packetData while it serialises the data phase.
//   Reports occupancy so the transmitter/controller can size and validate the packet.
//   First-word-fall-through: the head byte is always presented on tx_packet_data.
// PARAMETERS
//   DEPTH   64   number of byte entries; power of two, >= 2
//   ADDR_W  6    $clog2(DEPTH); pointer width. Occupancy width is ADDR_W+1.
// PORTS
//   clk                 in   1        system clock, rising edge
//   n_rst               in   1        asynchronous active-low reset
//   clear               in   1        synchronous flush of all contents
//   store_tx_data       in   1        push strobe, one byte per asserted cycle
//   tx_data             in   8        byte to push
//   get_tx_packetData   in   1        pop strobe from transmitter, one byte per asserted cycle
//   tx_packet_data      out  8        head byte (FWFT); 8'h00 when empty
//   buffer_occupancy    out  ADDR_W+1 bytes held, 0..DEPTH
//   buffer_full         out  1        buffer_occupancy == DEPTH
//   buffer_empty        out  1        buffer_occupancy == 0
// BEHAVIOUR
//   - Reset (n_rst=0, async): wptr=rptr=0, occupancy=0, buffer_empty=1, buffer_full=0, tx_packet_data=8'h00.
//     Memory contents are don't-care.
//   - All state updates occur on the rising clk edge. Outputs are registered/derived from registers:
//     no combinational path from any input to any output.
//   - Push (store_tx_data=1 and not full): mem[wptr]<=tx_data, wptr+1 mod DEPTH, occupancy+1.
//   - Pop (get_tx_packetData=1 and not empty): rptr+1 mod DEPTH, occupancy-1.
//     tx_packet_data shows the next byte the following cycle.
//   - Latency: a byte pushed into an empty buffer appears on tx_packet_data one cycle after the push edge.
//   - Push+pop same cycle, 0<occ<DEPTH: both performed, occupancy unchanged.
//   - Push+pop same cycle, empty: push only, pop ignored. The byte is not bypassed.
//   - Push+pop same cycle, full: both performed. The pop frees space this cycle, so the push is accepted.
//   - Push when full (no pop): byte dropped, no state change.
//   - Pop when empty: ignored; tx_packet_data stays 8'h00.
//   - clear=1: wptr=rptr=occupancy=0 next edge. Overrides push and pop in the same cycle.
//   - Pointers wrap DEPTH-1 -> 0 silently. Full/empty come from the occupancy counter, not pointer compare.
//   - Reset mid-packet: contents lost. The transmitter sees buffer_empty=1 immediately (async).
// CONFIGURATION
//   TX_BUF_ERR_EN defined:
//     - Adds output buffer_error (1 bit), sticky.
//     - Set on the edge after a dropped push (full, no pop) or an ignored pop (empty).
//     - Cleared by clear or n_rst.
//   TX_BUF_ERR_EN undefined:
//     - Port and logic absent; drops and ignored pops are silent. All other behaviour is identical.
// STRUCTURE
//   - usb_pkg holds:
//     - TX_BUF_DEPTH (64)
//     - typedef logic [7:0] byte_t
//     - typedef logic [$clog2(TX_BUF_DEPTH):0] occ_t
//     - shared with the transmitter and controller, which check occupancy against packet length
//   - One sub-module: tx_buf_ptr_ctrl (wptr/rptr/occupancy counters, push/pop qualification, full/empty).
//     Storage array and output mux stay in the top.
// TESTING
//   1. Reset, then push 8'hA5 -> next cycle tx_packet_data=8'hA5, occupancy=1, empty=0.
//   2. Push 64 bytes 0..63 -> full=1, occupancy=64. Push 8'hFF -> dropped, occupancy=64
//      (buffer_error=1 if TX_BUF_ERR_EN). Pop 64x -> reads 0..63 in order, empty=1.
//   3. Hold occupancy at 10, assert push+pop together for 100 cycles -> occupancy stays 10.
//      Order preserved across pointer wrap.
//   4. Full buffer, push 8'h55 + pop same cycle -> occupancy stays 64; 8'h55 is read last.
//   5. Empty buffer, pop -> no change, tx_packet_data=8'h00. Push+pop together -> occupancy=1,
//      head=pushed byte.
//   6. Occupancy 20, assert clear with push -> occupancy=0, empty=1.
//      Async n_rst mid-stream -> empty=1 without a clk edge.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB transmit-path types and sizing, used by the TX buffer, transmitter and controller.
package usb_pkg;

    localparam int TX_BUF_DEPTH = 64;

    typedef logic [7:0]                      byte_t;
    typedef logic [$clog2(TX_BUF_DEPTH):0]   occ_t;

    localparam byte_t TX_IDLE_BYTE = 8'h00;

endpackage : usb_pkg

// File: rtl/tx_buf_ptr_ctrl.sv
// Pointer/occupancy bookkeeping for tx_data_buffer: qualifies push/pop and derives full/empty.
// Optional sticky error flag when TX_BUF_ERR_EN is defined.
module tx_buf_ptr_ctrl
    import usb_pkg::*;
#(
    parameter int DEPTH  = TX_BUF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic              push_ok_o,
    output logic              pop_ok_o,
    output logic [ADDR_W-1:0] wptr_o,
    output logic [ADDR_W-1:0] rptr_o,
    output logic [ADDR_W:0]   occ_o,
    output logic              full_o,
    output logic              empty_o
`ifdef TX_BUF_ERR_EN
    ,
    output logic              error_o
`endif
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   OCC_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   OCC_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   OCC_ZERO = {(ADDR_W+1){1'b0}};

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              full_s, empty_s;
    logic              push_ok_s, pop_ok_s;

    assign full_s  = (occ_q == OCC_MAX);
    assign empty_s = (occ_q == OCC_ZERO);

    // A pop on a full buffer frees the slot the concurrent push lands in.
    assign pop_ok_s  = pop_i & ~empty_s & ~clear_i;
    assign push_ok_s = push_i & (~full_s | pop_ok_s) & ~clear_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (clear_i) begin
            wptr_d = {ADDR_W{1'b0}};
            rptr_d = {ADDR_W{1'b0}};
            occ_d  = OCC_ZERO;
        end else begin
            if (push_ok_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_ok_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= {ADDR_W{1'b0}};
            rptr_q <= {ADDR_W{1'b0}};
            occ_q  <= OCC_ZERO;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

`ifdef TX_BUF_ERR_EN
    logic err_q, err_d, err_evt_s;

    assign err_evt_s = (push_i & full_s & ~pop_i) | (pop_i & empty_s);

    // Sticky error next-state; clear wins over a same-cycle event.
    always_comb begin
        err_d = err_q;
        if (clear_i) begin
            err_d = 1'b0;
        end else if (err_evt_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_o = err_q;
`endif

    assign push_ok_o = push_ok_s;
    assign pop_ok_o  = pop_ok_s;
    assign wptr_o    = wptr_q;
    assign rptr_o    = rptr_q;
    assign occ_o     = occ_q;
    assign full_o    = full_s;
    assign empty_o   = empty_s;

endmodule : tx_buf_ptr_ctrl

// File: rtl/tx_data_buffer.sv
// First-word-fall-through byte FIFO feeding the USB transmitter.
// Define TX_BUF_ERR_EN to add the sticky buffer_error output.
module tx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH  = TX_BUF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  byte_t             tx_data,
    input  logic              get_tx_packetData,
    output byte_t             tx_packet_data,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              buffer_full,
    output logic              buffer_empty
`ifdef TX_BUF_ERR_EN
    ,
    output logic              buffer_error
`endif
);

    byte_t             mem_q [DEPTH];
    logic              push_ok_s;
    logic              pop_ok_s;
    logic [ADDR_W-1:0] wptr_s;
    logic [ADDR_W-1:0] rptr_s;
    logic [ADDR_W:0]   occ_s;
    logic              full_s;
    logic              empty_s;

    tx_buf_ptr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (clear),
        .push_i    (store_tx_data),
        .pop_i     (get_tx_packetData),
        .push_ok_o (push_ok_s),
        .pop_ok_o  (pop_ok_s),
        .wptr_o    (wptr_s),
        .rptr_o    (rptr_s),
        .occ_o     (occ_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
`ifdef TX_BUF_ERR_EN
        ,
        .error_o   (buffer_error)
`endif
    );

    // Payload storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_s] <= tx_data;
        end
    end

    // Head byte from registered state only; idle byte while empty so stale data never leaks.
    always_comb begin
        tx_packet_data = TX_IDLE_BYTE;
        if (empty_s) begin
            tx_packet_data = TX_IDLE_BYTE;
        end else begin
            tx_packet_data = mem_q[rptr_s];
        end
    end

    assign buffer_occupancy = occ_s;
    assign buffer_full      = full_s;
    assign buffer_empty     = empty_s;

endmodule : tx_data_buffer
